pr_skid_stage: RTL and testbench

Parametrised pipeline register with a valid/ready handshake and a 2-entry skid buffer. It generalises the fixed-field IF/ID register to any payload width and adds back-pressure without a combinational ready path. It also provides flush with optional payload clearing and a saturating back-pressure cycle counter. It is instantiated between any two core stages (IF/ID first, then ID/EX, EX/MEM) in place of the plain flush/stall registers.

---
 rtl/pr_skid_stage.sv | 148 ++++++++++++++
 tb/tb_pr_skid_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pr_skid_stage.sv
// pr_skid_stage
//   Pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//   It can sit between any two core stages. in_ready_o is a flop output, so
//   there is no combinational path from out_ready_i back to the upstream
//   stage. The stage also supports flush, with optional payload clearing, and
//   keeps a saturating count of back-pressure cycles.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      drop held entries and any entry offered this cycle
//   in_valid_i   upstream offers in_data_i
//   in_ready_o   stage can accept (registered, state != FULL)
//   in_data_i    upstream payload [DATA_W]
//   out_valid_o  main register holds a valid entry
//   out_ready_i  downstream accepts out_data_o this cycle
//   out_data_o   main register payload [DATA_W]
//   bp_cnt_o     saturating count of out_valid & !out_ready cycles [CNT_W]
//   bp_clr_i     synchronous clear of bp_cnt_o
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no entry held; out_valid=0, in_ready=1
// BUSY  | main holds the head entry; skid free; out_valid=1, in_ready=1
// FULL  | main holds the head, skid holds the second; in_ready=0

module pr_skid_stage #(
  parameter int unsigned DATA_W         = 96,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  bp_cnt_o,
  input  logic              bp_clr_i
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    bp_cnt_q, bp_cnt_d;

  logic                stall;

  // Downstream is holding off a valid entry this cycle.
  assign stall = out_valid_q & ~out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Whatever is offered or held this cycle is dropped. An output transfer
      // in the same cycle was already seen by downstream, so nothing else
      // is needed for it.
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid_i) begin
            main_d  = in_data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_valid_i && out_ready_i) begin
            main_d = in_data_i;
          end else if (in_valid_i) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_ready_i) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so in_valid_i is not looked at.
          if (out_ready_i) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    // Handshake outputs are derived from the next state so that they are
    // plain flops, with no path from out_ready_i to in_ready_o.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);

    // The counter saturates instead of wrapping. A clear takes priority over
    // a stall in the same cycle.
    bp_cnt_d = bp_cnt_q;
    if (bp_clr_i) begin
      bp_cnt_d = '0;
    end else if (stall && (bp_cnt_q != CNT_MAX)) begin
      bp_cnt_d = bp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      bp_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      bp_cnt_q    <= bp_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign bp_cnt_o    = bp_cnt_q;

endmodule

// File: tb/tb_pr_skid_stage.sv
module tb_pr_skid_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = 15;

  logic          clk;
  logic          rst, flush, in_valid, out_ready, bp_clr;
  logic [DW-1:0] in_data;

  logic          in_ready_c, out_valid_c;
  logic [DW-1:0] out_data_c;
  logic [CW-1:0] bp_cnt_c;

  logic          in_ready_k, out_valid_k;
  logic [DW-1:0] out_data_k;
  logic [CW-1:0] bp_cnt_k;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO queue of held entries plus the payload each variant
  // of the stage is expected to present.
  logic [DW-1:0] sb_q[$];
  logic          m_in_ready = 1'b1;
  logic [DW-1:0] m_main_c = '0;
  logic [DW-1:0] m_main_k = '0;
  int unsigned   m_cnt = 0;

  pr_skid_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) u_dut_clr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_c), .in_data_i(in_data),
    .out_valid_o(out_valid_c), .out_ready_i(out_ready), .out_data_o(out_data_c),
    .bp_cnt_o(bp_cnt_c), .bp_clr_i(bp_clr)
  );

  pr_skid_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) u_dut_keep (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_k), .in_data_i(in_data),
    .out_valid_o(out_valid_k), .out_ready_i(out_ready), .out_data_o(out_data_k),
    .bp_cnt_o(bp_cnt_k), .bp_clr_i(bp_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, flush, iv, ordy, clr;
    logic [DW-1:0] d;
    logic          e_ov, e_ir;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic r, logic f, logic iv, logic o, logic c,
                              logic [DW-1:0] d, logic ov, logic ir, logic [DW-1:0] od);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.clr = c; v.d = d;
    v.e_ov = ov; v.e_ir = ir; v.e_od = od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    logic out_x, in_x;
    if (rst) begin
      sb_q.delete();
      m_cnt = 0;
      m_main_c = '0;
      m_main_k = '0;
      m_in_ready = 1'b1;
    end else begin
      if (bp_clr) m_cnt = 0;
      else if (sb_q.size() != 0 && !out_ready && m_cnt != CMAX) m_cnt++;
      if (flush) begin
        sb_q.delete();
        m_main_c = '0;
      end else begin
        out_x = (sb_q.size() != 0) && out_ready;
        in_x  = in_valid && m_in_ready;
        if (out_x) void'(sb_q.pop_front());
        if (in_x) sb_q.push_back(in_data);
      end
      m_in_ready = (sb_q.size() < 2);
      if (sb_q.size() != 0) begin
        m_main_c = sb_q[0];
        m_main_k = sb_q[0];
      end
    end
  endtask

  task automatic model_check();
    chk("out_valid", 32'(out_valid_c), 32'(sb_q.size() != 0));
    chk("in_ready", 32'(in_ready_c), 32'(m_in_ready));
    chk("out_data", 32'(out_data_c), 32'(m_main_c));
    chk("bp_cnt", 32'(bp_cnt_c), m_cnt);
    chk("keep_out_valid", 32'(out_valid_k), 32'(sb_q.size() != 0));
    chk("keep_in_ready", 32'(in_ready_k), 32'(m_in_ready));
    chk("keep_out_data", 32'(out_data_k), 32'(m_main_k));
    chk("keep_bp_cnt", 32'(bp_cnt_k), m_cnt);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
  task automatic step(input logic r, input logic f, input logic iv, input logic o,
                      input logic c, input logic [DW-1:0] d);
    rst = r; flush = f; in_valid = iv; out_ready = o; bp_clr = c; in_data = d;
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bp_clr = 1'b0; in_data = '0;

    //              rst flush iv  ordy clr  data      ov   ir   od
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1,  1'b1, 1'b1, 16'h1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2,  1'b1, 1'b1, 16'h2);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3,  1'b1, 1'b1, 16'h3);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h4,  1'b1, 1'b1, 16'h4);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h4);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hA,  1'b1, 1'b1, 16'hA);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hB,  1'b1, 1'b0, 16'hA);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hC,  1'b1, 1'b0, 16'hA);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC,  1'b1, 1'b1, 16'hB);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC,  1'b1, 1'b1, 16'hC);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'hC);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h11, 1'b1, 1'b1, 16'h11);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h12, 1'b1, 1'b0, 16'h11);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hD,  1'b0, 1'b1, 16'h0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h0);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h20, 1'b1, 1'b1, 16'h20);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b1, 16'h20);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].clr, tbl[i].d);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid_c), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready_c), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_data", i), 32'(out_data_c), 32'(tbl[i].e_od));
      if (i == 15) chk("flush_keep_out_data", 32'(out_data_k), 32'h11);
      if (i == 17) chk("keep_overwrite", 32'(out_data_k), 32'h20);
    end

    // Back-pressure counter saturation and clear.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h55);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bp_saturate", 32'(bp_cnt_c), 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    chk("bp_clear", 32'(bp_cnt_c), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bp_after_clear", 32'(bp_cnt_c), 32'd1);

    // Reset while FULL with downstream ready: neither entry may appear.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h66);
    chk("full_before_rst", 32'(in_ready_c), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("rst_mid_valid", 32'(out_valid_c), 32'd0);
    chk("rst_mid_data", 32'(out_data_c), 32'd0);
    chk("rst_mid_keep_data", 32'(out_data_k), 32'd0);
    chk("rst_mid_bp", 32'(bp_cnt_c), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("rst_mid_no_emit", 32'(out_valid_c), 32'd0);

    // Flush held for several cycles while upstream keeps offering.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h77);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'(16'h80 + i));
      chk("flush_hold_empty", 32'(out_valid_c), 32'd0);
    end

    // Randomised traffic against the scoreboard model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 4), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
